// File: rtl/dec_disp_pkg.sv
// Shared constants for the multiplexed seven-segment driver.
// Segment patterns are {g,f,e,d,c,b,a}, active-low; anodes are active-low.
package dec_disp_pkg;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    // Inactive level of a single anode line.
    localparam logic AN_OFF = 1'b1;

    // Level of anode line k when digit idx is the one being lit.
    function automatic logic an_bit(input int idx, input int k);
        return (idx == k) ? ~AN_OFF : AN_OFF;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder; codes 10-15 show a dash.
module bcd_to_seg
    import dec_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/dec_scan_display.sv
// Multiplexed common-anode display driver: shadow BCD register, prescaled digit scan,
// registered active-low anode/segment outputs. Define DEC_SCAN_LZ_BLANK_EN for leading-zero blanking.
module dec_scan_display
    import dec_disp_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  dis,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  frame_done
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
    localparam logic [PW-1:0] PCNT_MAX = PW'(PRESCALE - 1);

    logic [DIGITS-1:0][3:0] shadow_q, shadow_d;
    logic [PW-1:0]          pcnt_q, pcnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [DIGITS-1:0]      an_q, an_d;
    logic [6:0]             seg_q, seg_d;
    logic                   frame_done_q, frame_done_d;

    logic       adv;
    logic [3:0] cur_digit;
    logic [6:0] cur_seg;
    logic       cur_blank;

    assign cur_digit = shadow_q[idx_q];

    bcd_to_seg u_bcd_to_seg (
        .bcd (cur_digit),
        .seg (cur_seg)
    );

`ifdef DEC_SCAN_LZ_BLANK_EN
    // lz[k] is set when digit k and every digit above it hold zero; digit 0 always shows.
    logic [DIGITS-1:0] lz;

    always_comb begin
        lz = '0;
        lz[DIGITS-1] = (shadow_q[DIGITS-1] == 4'd0);
        for (int k = DIGITS - 2; k >= 0; k--) begin
            lz[k] = lz[k+1] && (shadow_q[k] == 4'd0);
        end
        lz[0] = 1'b0;
    end

    assign cur_blank = lz[idx_q];
`else
    assign cur_blank = 1'b0;
`endif

    // Scan sequencing and shadow capture; the scan keeps running while disabled.
    always_comb begin
        adv          = (pcnt_q == PCNT_MAX);
        pcnt_d       = adv ? '0 : pcnt_q + 1'b1;
        idx_d        = idx_q;
        if (adv) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end
        frame_done_d = adv && (idx_q == IDX_MAX);
        shadow_d     = load ? bcd_in : shadow_q;
    end

    always_comb begin
        for (int k = 0; k < DIGITS; k++) begin
            an_d[k] = an_bit(int'(idx_q), k);
        end
        seg_d = cur_seg;
        if (dis || cur_blank) begin
            an_d  = {DIGITS{AN_OFF}};
            seg_d = SEG_OFF;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q     <= '0;
            pcnt_q       <= '0;
            idx_q        <= '0;
            an_q         <= {DIGITS{AN_OFF}};
            seg_q        <= SEG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            pcnt_q       <= pcnt_d;
            idx_q        <= idx_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

endmodule
